// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-requester SRAM arbiter.
package sram_arb_pkg;

    localparam int unsigned MAX_OUT_DEFAULT = 2;
    localparam int unsigned ADDR_W          = 32;
    localparam int unsigned DATA_W          = 32;
    localparam int unsigned STRB_W          = 4;
    // Sized for the largest legal MAX_OUT (4).
    localparam int unsigned PTR_W           = 2;
    localparam int unsigned CNT_W           = 3;

    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        LOCK_NONE = 2'd0,
        LOCK_INST = 2'd1,
        LOCK_DATA = 2'd2
    } lock_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [STRB_W-1:0] wstrb;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

    function automatic lock_e lock_of(owner_e owner);
        return (owner == OWNER_DATA) ? LOCK_DATA : LOCK_INST;
    endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester and memory-side signals of the SRAM arbiter.
interface sram_arbiter_if;
    import sram_arb_pkg::*;

    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [DATA_W-1:0] inst_rdata;

    logic              data_req;
    logic [STRB_W-1:0] data_wstrb;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    logic              mem_req;
    logic [STRB_W-1:0] mem_wstrb;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_addr_ok;
    logic              mem_data_ok;
    logic [DATA_W-1:0] mem_rdata;

    // Environment view: requesters plus memory.
    modport master (
        output inst_req, inst_addr, data_req, data_wstrb, data_addr, data_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  mem_req, mem_wstrb, mem_addr, mem_wdata
    );

    // Arbiter view.
    modport slave (
        input  inst_req, inst_addr, data_req, data_wstrb, data_addr, data_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output mem_req, mem_wstrb, mem_addr, mem_wdata
    );

endinterface

// File: rtl/sram_arb_owner_fifo.sv
// In-order record of which requester owns each outstanding memory transaction.
module sram_arb_owner_fifo
    import sram_arb_pkg::*;
#(
    parameter int unsigned DEPTH = MAX_OUT_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  owner_e           push_owner,
    input  logic             pop,
    output owner_e           head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    owner_e           slots [2**PTR_W];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = slots[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Owner storage needs no reset; only slots behind a valid count are read.
    always_ff @(posedge clk) begin
        if (do_push) slots[wr_ptr] <= push_owner;
    end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates the IF and EXE requesters onto one pipelined SRAM port and routes
// in-order responses back to the requester that issued each transaction.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned MAX_OUT = MAX_OUT_DEFAULT
) (
    input logic           clk,
    input logic           reset,
    sram_arbiter_if.slave bus
);

    lock_e            lock_q;
    lock_e            lock_d;
    owner_e           winner;
    owner_e           head;
    mem_cmd_t         inst_cmd;
    mem_cmd_t         data_cmd;
    mem_cmd_t         mem_cmd;
    logic             full;
    logic             empty;
    logic             accept;
    logic             pop;
    logic [CNT_W-1:0] count;
    logic             unused_count;

    assign inst_cmd = '{addr: bus.inst_addr, wstrb: '0, wdata: '0};
    assign data_cmd = '{addr: bus.data_addr, wstrb: bus.data_wstrb, wdata: bus.data_wdata};

    assign bus.mem_req = (bus.inst_req | bus.data_req) & ~full & ~reset;
    assign accept      = bus.mem_req & bus.mem_addr_ok;
    assign pop         = bus.mem_data_ok & ~empty & ~reset;

    // Grant selection and lock tracking: a stalled request keeps its grant until accepted.
    always_comb begin
        lock_d = lock_q;
        winner = bus.data_req ? OWNER_DATA : OWNER_INST;
        unique case (lock_q)
            LOCK_INST: winner = OWNER_INST;
            LOCK_DATA: winner = OWNER_DATA;
            default:   ;
        endcase
        if (bus.mem_req & ~bus.mem_addr_ok) begin
            lock_d = lock_of(winner);
        end else if (accept) begin
            lock_d = LOCK_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) lock_q <= LOCK_NONE;
        else       lock_q <= lock_d;
    end

    assign mem_cmd       = (winner == OWNER_DATA) ? data_cmd : inst_cmd;
    assign bus.mem_addr  = mem_cmd.addr;
    assign bus.mem_wstrb = mem_cmd.wstrb;
    assign bus.mem_wdata = mem_cmd.wdata;

    assign bus.inst_addr_ok = accept & (winner == OWNER_INST);
    assign bus.data_addr_ok = accept & (winner == OWNER_DATA);

    assign bus.inst_data_ok = pop & (head == OWNER_INST);
    assign bus.data_data_ok = pop & (head == OWNER_DATA);
    assign bus.inst_rdata   = bus.mem_rdata;
    assign bus.data_rdata   = bus.mem_rdata;

    sram_arb_owner_fifo #(
        .DEPTH (MAX_OUT)
    ) u_owner_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (accept),
        .push_owner (winner),
        .pop        (pop),
        .head       (head),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    assign unused_count = ^count;

endmodule
